// File: rtl/seq_divider.sv
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Restoring shift-subtract that resolves one quotient bit per clock. Divide-by-zero
// and signed overflow take a short fixed path. Result and valid are registered.
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [1:0]      funct,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      funct_q, funct_d;
  logic [XLEN-1:0] dvd_q, dvd_d;       // dividend, shifted out MSB first
  logic [XLEN-1:0] dsr_q, dsr_d;       // divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;       // partial remainder (or special remainder)
  logic [XLEN-1:0] quo_q, quo_d;       // quotient bits (or special quotient)
  logic [CW-1:0]   count_q, count_d;
  logic            quot_neg_q, quot_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;

  // Operand magnitudes and signs; only signed ops (funct[0]=0) look at the sign bits.
  logic            is_signed, sign1, sign2;
  logic [XLEN-1:0] abs1, abs2;

  assign is_signed = ~funct[0];
  assign sign1     = is_signed & op1[XLEN-1];
  assign sign2     = is_signed & op2[XLEN-1];
  assign abs1      = sign1 ? -op1 : op1;
  assign abs2      = sign2 ? -op2 : op2;

  // One restoring step. The shifted remainder can need XLEN+1 bits when the
  // divisor is large, so the compare and subtract are done one bit wider.
  logic [XLEN:0]   rem_ext, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt;

  assign rem_ext = {rem_q, dvd_q[XLEN-1]};
  assign diff    = rem_ext - {1'b0, dsr_q};
  assign ge      = (rem_ext >= {1'b0, dsr_q});
  assign rem_nxt = ge ? diff[XLEN-1:0] : rem_ext[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], ge};

  function automatic logic [XLEN-1:0] apply_sign(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  // Next-state and datapath control for IDLE -> RUN/FIX -> DONE -> IDLE.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d    = state_q;
    funct_d    = funct_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    count_d    = count_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    valid_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          funct_d = funct;
          if (op2 == '0) begin
            // Divide by zero: quotient all-ones, remainder is the dividend.
            quo_d      = '1;
            rem_d      = op1;
            quot_neg_d = 1'b0;
            rem_neg_d  = 1'b0;
            state_d    = S_FIX;
          end else if (is_signed && op1 == INT_MIN && op2 == '1) begin
            // Signed overflow: quotient is INT_MIN, remainder zero.
            quo_d      = INT_MIN;
            rem_d      = '0;
            quot_neg_d = 1'b0;
            rem_neg_d  = 1'b0;
            state_d    = S_FIX;
          end else begin
            dvd_d      = abs1;
            dsr_d      = abs2;
            rem_d      = '0;
            quo_d      = '0;
            count_d    = '0;
            quot_neg_d = sign1 ^ sign2;
            rem_neg_d  = sign1;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d   = rem_nxt;
        quo_d   = quo_nxt;
        dvd_d   = {dvd_q[XLEN-2:0], 1'b0};
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = funct_q[1] ? apply_sign(rem_neg_q, rem_nxt)
                                : apply_sign(quot_neg_q, quo_nxt);
        end
      end
      S_FIX: begin
        state_d  = S_DONE;
        valid_d  = 1'b1;
        result_d = funct_q[1] ? rem_q : quo_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: there are no memory arrays here, so every register can take a reset
    // value; non-blocking updates keep all registers sampling pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      funct_q    <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      count_q    <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct_q    <= funct_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      count_q    <= count_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign valid  = valid_q;
  assign result = result_q;

endmodule
